// File: rtl/layer_out_serializer_pkg.sv
// Shared definitions for the layer output serializer: FSM encoding, default word width
// and the index-width helper.
package layer_out_serializer_pkg;

  localparam int dataWidth = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    SEND    = 1'b1
  } state_t;

  // Width of a counter that indexes n slots; kept at least 1 bit for single-neuron layers.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layer_out_serializer_if.sv
// Bundle between a layer's parallel neuron outputs and the serial stream into the next layer.
interface layer_out_serializer_if #(
  parameter int NUM_NEURONS = 30,
  parameter int WIDTH       = 8
);
  logic [NUM_NEURONS-1:0]       in_valid;
  logic [NUM_NEURONS*WIDTH-1:0] in_data;
  logic                         out_ready;
  logic                         out_valid;
  logic [WIDTH-1:0]             out_data;
  logic                         out_last;
  logic                         overrun;

  modport master (
    input  in_valid, in_data, out_ready,
    output out_valid, out_data, out_last, overrun
  );

  modport slave (
    output in_valid, in_data, out_ready,
    input  out_valid, out_data, out_last, overrun
  );
endinterface

// File: rtl/layer_out_serializer.sv
// Collects one word per neuron (in any order, any grouping) into a register buffer, then
// streams the buffer out in slot order with valid/ready handshaking.
module layer_out_serializer
  import layer_out_serializer_pkg::*;
#(
  parameter int NUM_NEURONS = 30,
  parameter int WIDTH       = dataWidth
) (
  input logic                    clk,
  input logic                    rst,
  layer_out_serializer_if.master bus
);

  localparam int              IDX_W    = idx_width(NUM_NEURONS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

  state_t                 state;
  logic [NUM_NEURONS-1:0] mask;
  logic [NUM_NEURONS-1:0] nxt_mask;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       nxt_idx;
  logic [WIDTH-1:0]       buffer [NUM_NEURONS];
  logic [WIDTH-1:0]       first_word;
  logic                   out_valid_q;
  logic [WIDTH-1:0]       out_data_q;
  logic                   out_last_q;
  logic                   overrun_q;

  always_comb begin
    nxt_mask   = mask | bus.in_valid;
    nxt_idx    = idx + IDX_W'(1);
    // Slot 0 may be captured on the completing edge itself, so bypass the buffer.
    first_word = bus.in_valid[0] ? bus.in_data[0 +: WIDTH] : buffer[0];
  end

  // Parallel writes from every neuron in the same cycle rule out a RAM here.
  always_ff @(posedge clk) begin
    if (!rst && state == COLLECT) begin
      for (int i = 0; i < NUM_NEURONS; i++)
        if (bus.in_valid[i]) buffer[i] <= bus.in_data[i*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= COLLECT;
      mask        <= '0;
      idx         <= '0;
      overrun_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (&nxt_mask) begin
            state       <= SEND;
            mask        <= nxt_mask;
            idx         <= '0;
            out_valid_q <= 1'b1;
            out_data_q  <= first_word;
            out_last_q  <= (NUM_NEURONS == 1);
          end else begin
            mask <= nxt_mask;
          end
        end
        SEND: begin
          // Next layer's outputs arriving before this one has drained are dropped.
          if (|bus.in_valid) overrun_q <= 1'b1;
          if (bus.out_ready) begin
            if (idx == LAST_IDX) begin
              state       <= COLLECT;
              mask        <= '0;
              idx         <= '0;
              out_valid_q <= 1'b0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
            end else begin
              idx        <= nxt_idx;
              out_data_q <= buffer[nxt_idx];
              out_last_q <= (nxt_idx == LAST_IDX);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_layer_out_serializer.sv
// Directed bench for layer_out_serializer (4 neurons x 8 bits) with a word scoreboard.
module tb_layer_out_serializer;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_out_serializer_if #(.NUM_NEURONS(N), .WIDTH(W)) bus ();

  layer_out_serializer #(.NUM_NEURONS(N), .WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_word(input int i, input logic [W-1:0] v);
    bus.in_data[i*W +: W] = v;
  endtask

  task automatic push4(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic [W-1:0] d);
    sb.push_back('{data: a, last: 1'b0});
    sb.push_back('{data: b, last: 1'b0});
    sb.push_back('{data: c, last: 1'b0});
    sb.push_back('{data: d, last: 1'b1});
  endtask

  // Counts cycles with out_valid high from the current cycle until the layer drains.
  task automatic run_send(input int exp_cycles, input string tag);
    int cnt = 0;
    while (bus.out_valid === 1'b1 && cnt < 64) begin
      cnt++;
      tick();
    end
    chk(tag, cnt, exp_cycles);
    chk({tag, "_idle"}, bus.out_valid, 1'b0);
    chk({tag, "_drained"}, sb.size(), 0);
  endtask

  // Scoreboard side: pop on each transfer; idle outputs must read as zero.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        chk("sb_nonempty", (sb.size() != 0), 1'b1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          chk("word", bus.out_data, mon_e.data);
          chk("last", bus.out_last, mon_e.last);
        end
      end else if (bus.out_valid === 1'b0) begin
        chk("idle_last", bus.out_last, 1'b0);
        chk("idle_data", bus.out_data, '0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    rst           = 1'b1;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_last", bus.out_last, 1'b0);
    chk("rst_data", bus.out_data, '0);
    chk("rst_overrun", bus.overrun, 1'b0);
    rst = 1'b0;
    tick();

    // Simultaneous capture
    bus.in_data  = 32'h44332211;
    bus.in_valid = 4'b1111;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    tick();
    bus.in_valid = '0;
    bus.in_data  = $urandom;
    chk("simul_first_valid", bus.out_valid, 1'b1);
    run_send(4, "simul_cycles");

    // Staggered capture: bits 2,0,3,1
    bus.in_data = $urandom; set_word(2, 8'hA2); bus.in_valid = 4'b0100; tick();
    chk("stag_wait0", bus.out_valid, 1'b0);
    bus.in_data = $urandom; set_word(0, 8'hA0); bus.in_valid = 4'b0001; tick();
    chk("stag_wait1", bus.out_valid, 1'b0);
    bus.in_data = $urandom; set_word(3, 8'hA3); bus.in_valid = 4'b1000; tick();
    chk("stag_wait2", bus.out_valid, 1'b0);
    bus.in_data = $urandom; set_word(1, 8'hA1); bus.in_valid = 4'b0010;
    push4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    tick();
    bus.in_valid = '0;
    chk("stag_first_valid", bus.out_valid, 1'b1);
    run_send(4, "stag_cycles");

    // Backpressure on word index 1
    bus.in_data  = 32'hB3B2B1B0;
    bus.in_valid = 4'b1111;
    push4(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    tick();
    bus.in_valid = '0;
    cnt = 1;
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp_hold_valid", bus.out_valid, 1'b1);
      chk("bp_hold_data", bus.out_data, 8'hB1);
      chk("bp_hold_last", bus.out_last, 1'b0);
      cnt++;
      tick();
    end
    bus.out_ready = 1'b1;
    while (bus.out_valid === 1'b1 && cnt < 64) begin
      cnt++;
      tick();
    end
    chk("bp_cycles", cnt, 7);
    chk("bp_drained", sb.size(), 0);

    // Overrun during SEND
    bus.in_data  = 32'hC3C2C1C0;
    bus.in_valid = 4'b1111;
    push4(8'hC0, 8'hC1, 8'hC2, 8'hC3);
    tick();
    chk("ovr_before", bus.overrun, 1'b0);
    bus.in_data  = 32'hFF0000FF;
    bus.in_valid = 4'b1001;
    tick();
    bus.in_valid = '0;
    chk("ovr_set", bus.overrun, 1'b1);
    run_send(3, "ovr_cycles");
    tick();
    tick();
    chk("ovr_sticky", bus.overrun, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovr_cleared", bus.overrun, 1'b0);

    // Overwrite of slot 2, then reset mid-SEND at index 2
    bus.in_data = 32'h0; set_word(2, 8'h05); bus.in_valid = 4'b0100; tick();
    set_word(2, 8'h06); tick();
    bus.in_data = 32'hD3_77_D1_D0; bus.in_valid = 4'b1011;
    push4(8'hD0, 8'hD1, 8'h06, 8'hD3);
    tick();
    bus.in_valid = '0;
    chk("ow_first_valid", bus.out_valid, 1'b1);
    tick();
    tick();
    chk("ow_slot2", bus.out_data, 8'h06);
    rst          = 1'b1;
    bus.in_data  = 32'h99999999;
    bus.in_valid = 4'b1111;
    tick();
    rst          = 1'b0;
    bus.in_valid = '0;
    chk("mid_rst_valid", bus.out_valid, 1'b0);
    chk("mid_rst_last", bus.out_last, 1'b0);
    chk("mid_rst_data", bus.out_data, '0);
    sb.delete();
    tick();
    chk("rst_prio_idle", bus.out_valid, 1'b0);
    bus.in_data = 32'h00E2E1E0; bus.in_valid = 4'b0111; tick();
    chk("fresh_partial", bus.out_valid, 1'b0);
    bus.in_data = 32'hE3000000; bus.in_valid = 4'b1000;
    push4(8'hE0, 8'hE1, 8'hE2, 8'hE3);
    tick();
    bus.in_valid = '0;
    chk("fresh_first_valid", bus.out_valid, 1'b1);
    run_send(4, "fresh_cycles");
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/layer_out_serializer.md
LAYER_OUT_SERIALIZER -- requirements
Module: layer_out_serializer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 30, giving the number of neuron outputs collected per layer.
REQ-002 SHALL have parameter WIDTH, default 8, giving the width of one neuron output word and of the serial output word.
REQ-003 SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port in_valid, input, NUM_NEURONS bits: per-neuron outvalid pulses; bit i belongs to neuron i.
REQ-006 SHALL have port in_data, input, NUM_NEURONS*WIDTH bits: flattened neuron outputs; neuron i occupies bits [i*WIDTH +: WIDTH].
REQ-007 SHALL have port out_ready, input, 1 bit: downstream accepts the current word; tie high for a layer that cannot stall.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid word (drives next-layer myinputValid).
REQ-009 SHALL have port out_data, output, WIDTH bits: serial word (drives next-layer myinput).
REQ-010 SHALL have port out_last, output, 1 bit: high with out_valid on the word for neuron NUM_NEURONS-1.
REQ-011 SHALL have port overrun, output, 1 bit: sticky error flag, cleared only by rst.

Function
REQ-012 SHALL implement states COLLECT and SEND; COLLECT is the reset state.
REQ-013 In COLLECT, for each i with in_valid[i]=1, SHALL store in_data word i into buffer slot i and set captured-mask bit i.
REQ-014 A repeated in_valid[i] in COLLECT for an already captured slot SHALL overwrite slot i without raising an error.
REQ-015 When the mask becomes all ones, including a same-cycle final capture, SHALL move to SEND on the next edge with read index 0.
REQ-016 In SEND, SHALL assert out_valid with out_data equal to buffer[index]; the first word is visible the cycle after the completing capture edge.
REQ-017 A word SHALL transfer on any edge where out_valid and out_ready are both 1; index then increments by 1.
REQ-018 While out_ready=0, out_valid, out_data and out_last SHALL hold stable.
REQ-019 On the transfer with index NUM_NEURONS-1, SHALL clear the mask and index and return to COLLECT; out_valid SHALL be 0 on the following cycle.
REQ-020 With out_ready held high, SEND SHALL last exactly NUM_NEURONS cycles.
REQ-021 Any in_valid bit high while in SEND SHALL set overrun, and that data SHALL be discarded; buffer contents SHALL be unchanged.
REQ-022 In COLLECT, out_valid and out_last SHALL be 0; out_data is don't-care but SHALL be driven as 0.
REQ-023 The buffer SHALL store words unmodified, with no arithmetic, sign extension or truncation.
REQ-024 The index counter SHALL be clog2(NUM_NEURONS) bits and SHALL never exceed NUM_NEURONS-1.

Reset
REQ-025 When rst=1 at an edge, SHALL go to COLLECT and clear the mask, index and overrun, and drive out_valid=0, out_last=0 and out_data=0.
REQ-026 Reset mid-SEND or mid-COLLECT SHALL abandon the partial layer; the buffer need not be cleared.
REQ-027 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-028 The state encoding constants (COLLECT, SEND) SHALL reside in the shared project package/include, alongside dataWidth.
REQ-029 The block SHALL be a single module with no sub-module; the buffer SHALL be a register array, not a RAM, because of parallel writes.

Verification (bench: NUM_NEURONS=4, WIDTH=8)
REQ-030 Simultaneous capture: in_valid=4'b1111 with words 0x11,0x22,0x33,0x44 and out_ready=1 -> next 4 cycles emit 0x11,0x22,0x33,0x44; out_last only on 0x44; then out_valid=0.
REQ-031 Staggered capture: in_valid bits 2,0,3,1 on successive cycles -> out_valid first rises the cycle after bit 1 arrives; order is slot 0..3.
REQ-032 Backpressure: out_ready=0 for 3 cycles on word index 1 -> out_data holds buffer[1] stable; total SEND duration is 7 cycles.
REQ-033 Overrun: in_valid[0]=1 with 0xFF during SEND -> overrun=1 and stays 1; emitted words unchanged; a later rst clears overrun.
REQ-034 Overwrite and reset: slot 2 written 0x05 then 0x06 before completion -> 0x06 emitted; rst asserted mid-SEND at index 2 -> out_valid=0 next cycle, and a fresh layer then serializes correctly from index 0.
